// File: rtl/regfile_arbiter_pkg.sv
// Shared types and constants for the two-requester register-file arbiter.
package regfile_arbiter_pkg;

    typedef enum logic [1:0] {
        RR       = 2'd0,
        LOCKED   = 2'd1,
        COOLDOWN = 2'd2
    } arb_state_e;

    localparam int CORE  = 0;
    localparam int DEBUG = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time wins.
module rr_arbiter2
    import regfile_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid[CORE] && valid[DEBUG]) begin
            if (rr_last) grant[CORE]  = 1'b1;
            else         grant[DEBUG] = 1'b1;
        end else if (valid[CORE]) begin
            grant[CORE] = 1'b1;
        end else if (valid[DEBUG]) begin
            grant[DEBUG] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates core and debug access to a register file, with a timed exclusive debug lock.
//   state    | meaning
//   RR       | round-robin between core and debug
//   LOCKED   | debug owns the file, lock counter running
//   COOLDOWN | one cycle after a lock timeout, core has strict priority
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int unsigned DW           = 8,
    parameter int unsigned AW           = 2,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_we,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    input  logic            lock_req,
    output logic            lock_active,
    output logic [1:0]      resp_valid,
    output logic [DW-1:0]   resp_rdata,
    output logic            rf_reg_write,
    output logic [AW-1:0]   rf_write_reg,
    output logic [DW-1:0]   rf_write_data,
    output logic [AW-1:0]   rf_read_reg,
    input  logic [DW-1:0]   rf_read_data
);

    localparam logic [7:0] LOCK_LOAD = 8'(LOCK_TIMEOUT);

    arb_state_e    state_q, state_d;
    logic          rr_last_q, rr_last_d;
    logic [7:0]    lock_cnt_q, lock_cnt_d;
    logic          lock_armed_q, lock_armed_d;
    logic [1:0]    resp_valid_q, resp_valid_d;
    logic [DW-1:0] resp_rdata_q, resp_rdata_d;

    logic [1:0]    arb_valid;
    logic          arb_last;
    logic [1:0]    arb_grant;
    logic          gnt_any;
    logic          gnt_idx;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // LOCKED hides the core; COOLDOWN forces the tie-break towards the core.
    always_comb begin
        arb_valid = req_valid;
        arb_last  = rr_last_q;
        case (state_q)
            LOCKED:   arb_valid = {req_valid[DEBUG], 1'b0};
            COOLDOWN: arb_last  = 1'b1;
            default:  ;
        endcase
    end

    rr_arbiter2 u_rr_arbiter2 (
        .valid   (arb_valid),
        .rr_last (arb_last),
        .grant   (arb_grant)
    );

    assign req_ready = rst_n ? arb_grant : 2'b00;
    assign gnt_any   = |req_ready;
    assign gnt_idx   = req_ready[DEBUG];
    assign sel_we    = req_we[gnt_idx];
    assign sel_addr  = gnt_idx ? req_addr[AW +: AW]  : req_addr[0 +: AW];
    assign sel_wdata = gnt_idx ? req_wdata[DW +: DW] : req_wdata[0 +: DW];

    assign rf_reg_write  = gnt_any & sel_we;
    assign rf_write_reg  = rf_reg_write ? sel_addr  : '0;
    assign rf_write_data = rf_reg_write ? sel_wdata : '0;
    assign rf_read_reg   = (gnt_any && !sel_we) ? sel_addr : '0;

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        lock_armed_d = lock_armed_q | ~lock_req;
        rr_last_d    = gnt_any ? gnt_idx : rr_last_q;
        resp_valid_d = req_ready;
        resp_rdata_d = (gnt_any && !sel_we) ? rf_read_data : '0;
        case (state_q)
            RR: begin
                if (lock_req && lock_armed_q) begin
                    state_d    = LOCKED;
                    lock_cnt_d = LOCK_LOAD;
                end
            end
            LOCKED: begin
                if (!lock_req) begin
                    state_d    = RR;
                    lock_cnt_d = 8'd0;
                end else if (lock_cnt_q <= 8'd1) begin
                    // Timeout: lock_req must drop before it can lock again.
                    state_d      = COOLDOWN;
                    lock_cnt_d   = 8'd0;
                    lock_armed_d = 1'b0;
                end else begin
                    lock_cnt_d = lock_cnt_q - 8'd1;
                end
            end
            COOLDOWN: state_d = RR;
            default:  state_d = RR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RR;
            rr_last_q    <= 1'b1;
            lock_cnt_q   <= 8'd0;
            lock_armed_q <= 1'b1;
            resp_valid_q <= 2'b00;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_armed_q <= lock_armed_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign lock_active = (state_q == LOCKED);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: expected responses are queued at issue and checked by a monitor.
module tb_regfile_arbiter;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int LT = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic            lock_req;
    logic            lock_active;
    logic [1:0]      resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic            rf_reg_write;
    logic [AW-1:0]   rf_write_reg;
    logic [DW-1:0]   rf_write_data;
    logic [AW-1:0]   rf_read_reg;
    logic [DW-1:0]   rf_read_data;

    logic            rf_init;
    logic [DW-1:0]   regs [4];
    int              cyc = 0;
    int              n_vec = 0;
    int              n_err = 0;

    typedef struct {
        int            idx;
        logic [DW-1:0] rdata;
        int            due;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    regfile_arbiter #(.DW(DW), .AW(AW), .LOCK_TIMEOUT(LT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .lock_req      (lock_req),
        .lock_active   (lock_active),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .rf_reg_write  (rf_reg_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_read_reg   (rf_read_reg),
        .rf_read_data  (rf_read_data)
    );

    // Register file model with its own preload (A0..A3).
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 4; i++) regs[i] <= 8'hA0 + 8'(i);
        end else if (rf_reg_write) begin
            regs[rf_write_reg] <= rf_write_data;
        end
    end
    assign rf_read_data = regs[rf_read_reg];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every resp_valid pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (resp_valid[i]) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL resp_unexpected @cyc %0d: got resp_valid[%0d] want none", cyc, i);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_vec++;
                    if (e.idx != i || e.rdata !== resp_rdata || e.due != cyc) begin
                        n_err++;
                        $display("FAIL resp @cyc %0d: got req%0d data %0h want req%0d data %0h due %0d",
                                 cyc, i, resp_rdata, e.idx, e.rdata, e.due);
                    end
                end
            end
        end
        while (sb.size() > 0 && sb[0].due < cyc) begin
            exp_t m;
            m = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL resp_missing @cyc %0d: got nothing want req%0d due %0d", cyc, m.idx, m.due);
        end
    end

    task automatic vec(input logic [1:0] v, input logic [1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic lk,
                       input logic [1:0] exp_rdy, input logic exp_la, input logic [DW-1:0] exp_rd);
        exp_t e;
        int   idx;
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        lock_req  = lk;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("lock_active", 32'(lock_active), 32'(exp_la));
        if (exp_rdy != 2'b00) begin
            idx     = exp_rdy[1] ? 1 : 0;
            e.idx   = idx;
            e.rdata = we[idx] ? '0 : exp_rd;
            e.due   = cyc + 1;
            sb.push_back(e);
            chk("rf_reg_write", 32'(rf_reg_write), 32'(we[idx]));
            if (we[idx]) begin
                chk("rf_write_reg", 32'(rf_write_reg), 32'(idx ? a1 : a0));
                chk("rf_write_data", 32'(rf_write_data), 32'(idx ? d1 : d0));
                chk("rf_read_reg_wr", 32'(rf_read_reg), 32'd0);
            end else begin
                chk("rf_read_reg", 32'(rf_read_reg), 32'(idx ? a1 : a0));
            end
        end else begin
            chk("rf_reg_write_idle", 32'(rf_reg_write), 32'd0);
            chk("rf_read_reg_idle", 32'(rf_read_reg), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rf_init   = 1'b1;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_we    = 2'b11;
        req_addr  = '0;
        req_wdata = '0;
        lock_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rf_init = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_lock_active", 32'(lock_active), 32'd0);
        chk("rst_rf_reg_write", 32'(rf_reg_write), 32'd0);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        @(posedge clk);
        #1;

        // core write then read of addr 2
        vec(2'b01, 2'b01, 2'd2, 2'd0, 8'h55, 8'h00, 1'b0, 2'b01, 1'b0, 8'h00);
        vec(2'b01, 2'b00, 2'd2, 2'd0, 8'h00, 8'h00, 1'b0, 2'b01, 1'b0, 8'h55);
        vec(2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00);
        vec(2'b10, 2'b00, 2'd0, 2'd2, 8'h00, 8'h00, 1'b0, 2'b10, 1'b0, 8'h55);

        // continuous tie alternates core, debug
        vec(2'b11, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0, 2'b01, 1'b0, 8'hA0);
        vec(2'b11, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0, 2'b10, 1'b0, 8'hA1);
        vec(2'b11, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0, 2'b01, 1'b0, 8'hA0);
        vec(2'b11, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0, 2'b10, 1'b0, 8'hA1);

        // cross-requester read-after-write
        vec(2'b01, 2'b01, 2'd3, 2'd0, 8'h3C, 8'h00, 1'b0, 2'b01, 1'b0, 8'h00);
        vec(2'b10, 2'b00, 2'd0, 2'd3, 8'h00, 8'h00, 1'b0, 2'b10, 1'b0, 8'h3C);

        // lock held to timeout (4 cycles), cooldown, no re-lock while held
        vec(2'b11, 2'b00, 2'd0, 2'd3, 8'h00, 8'h00, 1'b1, 2'b01, 1'b0, 8'hA0);
        repeat (LT) vec(2'b11, 2'b00, 2'd0, 2'd3, 8'h00, 8'h00, 1'b1, 2'b10, 1'b1, 8'h3C);
        vec(2'b11, 2'b00, 2'd0, 2'd3, 8'h00, 8'h00, 1'b1, 2'b01, 1'b0, 8'hA0);
        vec(2'b11, 2'b00, 2'd0, 2'd3, 8'h00, 8'h00, 1'b1, 2'b10, 1'b0, 8'h3C);
        vec(2'b11, 2'b00, 2'd0, 2'd3, 8'h00, 8'h00, 1'b1, 2'b01, 1'b0, 8'hA0);
        vec(2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00);

        // lock released early; held core write proceeds after release
        vec(2'b10, 2'b00, 2'd0, 2'd3, 8'h00, 8'h00, 1'b1, 2'b10, 1'b0, 8'h3C);
        vec(2'b11, 2'b01, 2'd1, 2'd3, 8'h77, 8'h00, 1'b1, 2'b10, 1'b1, 8'h3C);
        vec(2'b11, 2'b01, 2'd1, 2'd3, 8'h77, 8'h00, 1'b1, 2'b10, 1'b1, 8'h3C);
        vec(2'b11, 2'b01, 2'd1, 2'd3, 8'h77, 8'h00, 1'b0, 2'b10, 1'b1, 8'h3C);
        vec(2'b11, 2'b01, 2'd1, 2'd3, 8'h77, 8'h00, 1'b0, 2'b01, 1'b0, 8'h00);
        vec(2'b10, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0, 2'b10, 1'b0, 8'h77);

        // reset while a read response is in flight and the lock is active
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = '0;
        lock_req  = 1'b1;
        @(negedge clk);
        chk("mid_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("mid_resp_live", 32'(resp_valid), 32'd1);
        chk("mid_lock_live", 32'(lock_active), 32'd1);
        rst_n     = 1'b0;
        req_we    = 2'b01;
        req_wdata = {8'h00, 8'hEE};
        #1;
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("arst_lock_active", 32'(lock_active), 32'd0);
        chk("arst_rf_reg_write", 32'(rf_reg_write), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        lock_req  = 1'b0;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        vec(2'b11, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0, 2'b01, 1'b0, 8'hA0);
        vec(2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
